// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification for multicycle_alu.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: MULTICYCLE_ALU_DIV_EN (adds opcode 101 DIVU to the iterative class).
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for opcodes that run through the iterative unit instead of the one-cycle path.
  function automatic logic is_iter_op(input logic [2:0] op);
`ifdef MULTICYCLE_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply (low WIDTH bits), optional restoring unsigned divide.
// Latency: operands captured on start, WIDTH iterations on the following edges, done on the last.
// Backpressure: none; the FSM only pulses start when idle and consumes result on done.
// Ports: clk, reset_n (sync, active low), start, is_div (only with MULTICYCLE_ALU_DIV_EN),
//        a/b operands, done (combinational, high in the cycle of the final iteration), result.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef MULTICYCLE_ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  // acc: product accumulator (MUL) or partial remainder (DIVU)
  // x:   shifting multiplicand (MUL) or dividend shifting into quotient (DIVU)
  // y:   shifting multiplier (MUL) or fixed divisor (DIVU)
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] nxt_acc, nxt_x, nxt_y;

`ifdef MULTICYCLE_ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_sh, diff;
  logic             take;
`endif

  always_comb begin
    nxt_acc = acc + (y[0] ? x : '0);
    nxt_x   = x << 1;
    nxt_y   = y >> 1;
`ifdef MULTICYCLE_ALU_DIV_EN
    // Remainder stays below the divisor, so one extra bit holds the shifted value and
    // the sign of the trial subtraction.
    rem_sh = {acc, x[WIDTH-1]};
    diff   = rem_sh - {1'b0, y};
    take   = ~diff[WIDTH];
    if (div_q) begin
      nxt_y   = y;
      nxt_acc = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      nxt_x   = {x[WIDTH-2:0], take};
    end
    result = div_q ? nxt_x : nxt_acc;
`else
    result = nxt_acc;
`endif
  end

  // The FSM latches result in the same edge that performs the final iteration.
  assign done = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      x    <= '0;
      y    <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      acc  <= '0;
      x    <= a;
      y    <= b;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_q <= is_div;
`endif
    end else if (busy) begin
      acc  <= nxt_acc;
      x    <= nxt_x;
      y    <= nxt_y;
      cnt  <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: AND/OR/ADD/SUB/SLT in one cycle, MUL (and DIVU with MULTICYCLE_ALU_DIV_EN) iterative.
// Latency: out_valid 1 cycle after accept for single-cycle/illegal ops, WIDTH+1 cycles for MUL/DIVU.
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready only in IDLE.
// Ports: clk, reset_n (sync, active low), in_valid/in_ready request handshake, SrcA/SrcB/ALUControl
//        request fields, out_valid/out_ready result handshake, ALUResult/Zero/Overflow/IllegalOp.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             IllegalOp
);

  state_t           state;
  logic             accept;
  logic             iter_start, iter_done;
  logic [WIDTH-1:0] iter_result;
  logic [WIDTH-1:0] sum, dif, sc_res;
  logic             sc_ovf, sc_ill;

  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_iter_op(ALUControl);

  // One-cycle path, evaluated on the raw inputs and captured on the accept edge.
  always_comb begin
    sum    = SrcA + SrcB;
    dif    = SrcA - SrcB;
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (ALUControl)
      OP_AND: sc_res = SrcA & SrcB;
      OP_OR:  sc_res = SrcA | SrcB;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (dif[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_MUL: ;
`ifdef MULTICYCLE_ALU_DIV_EN
      OP_DIVU: ;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (iter_start),
`ifdef MULTICYCLE_ALU_DIV_EN
    .is_div  (ALUControl == OP_DIVU),
`endif
    .a       (SrcA),
    .b       (SrcB),
    .done    (iter_done),
    .result  (iter_result)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (is_iter_op(ALUControl)) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              ALUResult <= sc_res;
              Zero      <= (sc_res == '0);
              Overflow  <= sc_ovf;
              IllegalOp <= sc_ill;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            ALUResult <= iter_result;
            Zero      <= (iter_result == '0);
            Overflow  <= 1'b0;
            IllegalOp <= 1'b0;
          end
        end
        ST_DONE: begin
          // in_ready rises on this edge, so the earliest new accept is the next edge.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: driver pushes model results on accept, monitor pops on output.
// Latency: checked against the model (1 cycle one-cycle ops, 33 cycles iterative at WIDTH=32).
// Backpressure: monitor holds out_ready low for random or forced stretches and checks stability.
module tb_multicycle_alu;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         il;
    int           lat;
    time          t_acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA, SrcB;
  logic [2:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Zero, Overflow, IllegalOp;

  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];
  bit   force_hold = 1'b0;
  bit   rdy_bad = 1'b0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Overflow   (Overflow),
    .IllegalOp  (IllegalOp)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    exp_t e;
    longint sa, sbv, s;
    longint unsigned p;
    e.res = '0; e.ov = 1'b0; e.il = 1'b0; e.lat = 1; e.t_acc = 0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin s = sa + sbv; e.res = s[W-1:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b110: begin s = sa - sbv; e.res = s[W-1:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'b111: e.res = (sa < sbv) ? 1 : 0;
      3'b011: begin p = {32'b0, a} * {32'b0, b}; e.res = p[W-1:0]; e.lat = W + 1; end
`ifdef MULTICYCLE_ALU_DIV_EN
      3'b101: begin e.res = (b == 0) ? {W{1'b1}} : a / b; e.lat = W + 1; end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic scramble();
    in_valid   = 1'($urandom_range(0, 1));
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = 3'($urandom);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input bit track);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 300) begin
      scramble();
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; SrcA = a; SrcB = b; ALUControl = op;
    @(posedge clk);
    if (track) begin
      e = model(a, b, op);
      e.t_acc = $time;
      sb.push_back(e);
    end
    #1 scramble();
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", (sb.size() == 0) && in_ready, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor / consumer
  initial begin
    exp_t e;
    int   hold;
    bit   seen, post;
    int   lat_got;
    out_ready = 1'b0;
    hold = 0; seen = 0; post = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        out_ready = 1'b0; seen = 0; post = 0; rdy_bad = 0;
      end else if (post) begin
        out_ready = 1'b0;
        post = 0;
        check("after_handshake_out_valid", out_valid, 0);
        check("after_handshake_in_ready", in_ready, 1);
      end else begin
        if (sb.size() > 0 && in_ready) rdy_bad = 1'b1;
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            e = sb[0];
            if (!seen) begin
              lat_got = int'(($time - e.t_acc + 5) / 10);
              check("latency", lat_got, e.lat);
              check("in_ready_low_while_busy", rdy_bad, 0);
              check("result", ALUResult, e.res);
              check("zero", Zero, e.z);
              check("overflow", Overflow, e.ov);
              check("illegal", IllegalOp, e.il);
              rdy_bad = 1'b0;
              seen = 1;
              if (force_hold) begin hold = 5; force_hold = 1'b0; end
              else hold = $urandom_range(0, 3);
            end else begin
              check("stable_result", ALUResult, e.res);
              check("stable_flags", {Zero, Overflow, IllegalOp}, {e.z, e.ov, e.il});
            end
            if (hold == 0) begin
              check("in_ready_low_in_done", in_ready, 0);
              out_ready = 1'b1;
              void'(sb.pop_front());
              seen = 0;
              post = 1;
            end else begin
              hold--;
              out_ready = 1'b0;
            end
          end
        end
      end
    end
  end

  // Driver
  initial begin
    logic [2:0] op;
    reset_n = 1'b0; in_valid = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", ALUResult, 0);
    check("rst_flags", {Zero, Overflow, IllegalOp}, 3'b100);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    issue(32'd5, 32'd8, 3'b010, 1);
    issue(32'h7FFF_FFFF, 32'd1, 3'b010, 1);
    issue(32'd5, 32'd5, 3'b110, 1);
    issue(32'd6, 32'd7, 3'b011, 1);
    drain();
    force_hold = 1'b1;
    issue(32'd1234, 32'd4321, 3'b010, 1);
    issue(32'd100, 32'd7, 3'b101, 1);
    issue(32'd100, 32'd0, 3'b101, 1);
    issue(32'd3, 32'd9, 3'b100, 1);
    issue(32'h8000_0000, 32'd1, 3'b110, 1);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      issue(pick(), pick(), op, 1);
    end
    drain();

    // Reset in the middle of a multiply; the aborted result must never appear.
    issue(32'd6, 32'd7, 3'b011, 0);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", ALUResult, 0);
    check("midrst_zero", Zero, 1);
    check("midrst_in_ready", in_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_release_in_ready", in_ready, 1);
    issue(32'hFFFF_FFFF, 32'd0, 3'b111, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits (legal range 8..64).
REQ-002 Port clk  input  1: SHALL be the single clock; every flop updates on its rising edge.
REQ-003 Port reset_n  input  1: SHALL be a synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 Port in_valid  input  1: SHALL mean an operation request is present.
REQ-005 Port in_ready  output  1: SHALL mean the block can accept a request this cycle.
REQ-006 Port SrcA, SrcB  input  WIDTH each: SHALL be the operands.
REQ-007 Port ALUControl  input  3: SHALL be the operation select.
REQ-008 Port out_valid  output  1: SHALL mean the result is presented.
REQ-009 Port out_ready  input  1: SHALL mean the consumer takes the result this cycle.
REQ-010 Port ALUResult  output  WIDTH: SHALL carry the result.
REQ-011 Port Zero  output  1: SHALL be high when ALUResult is all zeros.
REQ-012 Port Overflow  output  1: SHALL be the signed overflow of ADD/SUB; 0 for every other op.
REQ-013 Port IllegalOp  output  1: SHALL flag an unsupported ALUControl code.

Function
REQ-014 Opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed; result 1 or 0), 011 MUL (low WIDTH bits, unsigned shift-add), 101 DIVU (quotient, macro-gated).
REQ-015 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-016 in_ready SHALL be high only in IDLE; a request is accepted when in_valid and in_ready are both high on a rising edge.
REQ-017 On accept, the block SHALL register the operands and opcode.
REQ-018 Single-cycle ops SHALL go IDLE->DONE, giving out_valid one cycle after accept.
REQ-019 MUL SHALL go IDLE->BUSY, run exactly WIDTH iterations, then go to DONE: out_valid WIDTH+1 cycles after accept.
REQ-020 DIVU SHALL be restoring and use the same BUSY timing as MUL.
REQ-021 In DONE, ALUResult/Zero/Overflow/IllegalOp SHALL stay stable until out_ready is high; then the FSM SHALL return to IDLE.
REQ-022 The FSM SHALL NOT accept a new request in the cycle it leaves DONE (no bypass).
REQ-023 Input changes while in BUSY or DONE SHALL be ignored.
REQ-024 An illegal opcode SHALL go to DONE in one cycle with ALUResult=0, Zero=1, IllegalOp=1.
REQ-025 DIVU with SrcB=0 SHALL return all ones with no error flag.
REQ-026 ADD/SUB SHALL wrap modulo 2^WIDTH.

Reset
REQ-027 While reset_n=0 at a clock edge: state=IDLE, in_ready=0 during reset and 1 in the first cycle after release, out_valid=0, ALUResult=0, Zero=1, Overflow=0, IllegalOp=0.
REQ-028 Reset in BUSY or DONE SHALL abort the operation and discard the pending result.

Configuration
REQ-029 Macro MULTICYCLE_ALU_DIV_EN defined: opcode 101 SHALL perform DIVU.
REQ-030 Macro MULTICYCLE_ALU_DIV_EN undefined: opcode 101 SHALL be illegal (REQ-024) and no divider logic SHALL be built.

Structure
REQ-031 The opcode constants and FSM state encodings SHALL live in the shared package alu_pkg.
REQ-032 The iterative MUL/DIVU datapath SHALL be a sub-module named alu_iter_unit, with start/done handshake to the FSM.

Verification
REQ-033 Case 1: SrcA=5, SrcB=8, op 010 -> out_valid one cycle after accept; ALUResult=13, Zero=0, Overflow=0.
REQ-034 Case 2: SrcA=0x7FFFFFFF, SrcB=1, op 010 -> ALUResult=0x80000000, Overflow=1; SrcA=5, SrcB=5, op 110 -> ALUResult=0, Zero=1.
REQ-035 Case 3: SrcA=6, SrcB=7, op 011 -> ALUResult=42 exactly 33 cycles after accept; in_ready=0 throughout.
REQ-036 Case 4: hold out_ready=0 for 5 cycles in DONE while changing SrcA -> result stable; in_ready returns 1 the cycle after out_ready=1.
REQ-037 Case 5: with the macro, SrcA=100, SrcB=7, op 101 -> ALUResult=14; SrcB=0 -> ALUResult=0xFFFFFFFF. Without the macro, op 101 -> IllegalOp=1.
REQ-038 Case 6: assert reset_n=0 mid-MUL -> next cycle out_valid=0, ALUResult=0, Zero=1; the block then accepts SrcA=-1, SrcB=0, op 111 -> ALUResult=1.
